patp_control: RTL

//  Fetch/decode/execute sequencer for the PATP core. Consumes the opcode held in ir
//  and drives every datapath enable: MAR load/select, the IR load strobe (clk_ir),
//  PC increment/load, D-register ops and memory write. Memory read is asynchronous
//  and memory write is synchronous. One instruction takes 3 cycles (reg/jump ops) or
//  4 cycles (memory ops), plus one IDLE cycle whenever the core is stopped.

---
 rtl/patp_pkg.sv | 28 ++
 rtl/patp_edge_detect.sv | 18 +
 rtl/patp_control.sv | 116 +++++++++++
 3 files changed

// File: rtl/patp_pkg.sv
// rtl/patp_pkg.sv - opcodes, state encodings and widths for the PATP sequencer
package patp_pkg;

  localparam int OPC_W_DEF = 3;

  localparam logic [2:0] OP_CLR   = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_BNZ   = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_LOAD  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_IRLD  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_MEM   = 3'd4
  } state_t;

  // Memory-operand instructions take the extra MEM cycle.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_STORE) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/patp_edge_detect.sv
// rtl/patp_edge_detect.sv - rising-edge detector turning a held level into a one-cycle pulse
module patp_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule

// File: rtl/patp_control.sv
// rtl/patp_control.sv - fetch/decode/execute sequencer driving all PATP datapath enables
module patp_control
  import patp_pkg::*;
#(
  parameter int OPC_W     = OPC_W_DEF,
  parameter int STEP_EDGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             d_zero,
  input  logic             run,
  input  logic             step,
  output logic             ld_mar,
  output logic             mar_sel,
  output logic             clk_ir,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             d_clr,
  output logic             d_inc,
  output logic             d_dec,
  output logic             d_add,
  output logic             d_load,
  output logic             mem_wr,
  output logic             busy,
  output logic [2:0]       state
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [2:0] op;
  logic       step_go;

  assign op = opcode[2:0];

  generate
    if (STEP_EDGE != 0) begin : g_step_edge
      patp_edge_detect u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (step),
        .pulse (step_go)
      );
    end else begin : g_step_level
      assign step_go = step;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Instruction end returns to FETCH only while free-running; a step runs one instruction.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = (run || step_go) ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_d = ST_IRLD;
      ST_IRLD:  state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_mem_op(op)) state_d = ST_MEM;
        else               state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_MEM:   state_d = run ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ld_mar  = 1'b0;
    mar_sel = 1'b0;
    clk_ir  = 1'b0;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    d_clr   = 1'b0;
    d_inc   = 1'b0;
    d_dec   = 1'b0;
    d_add   = 1'b0;
    d_load  = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      ST_FETCH: ld_mar = 1'b1;
      ST_IRLD: begin
        clk_ir = 1'b1;
        pc_inc = 1'b1;
      end
      ST_EXEC: begin
        case (op)
          OP_CLR: d_clr = 1'b1;
          OP_INC: d_inc = 1'b1;
          OP_DEC: d_dec = 1'b1;
          OP_JMP: pc_ld = 1'b1;
          OP_BNZ: pc_ld = ~d_zero;
          default: begin
            ld_mar  = 1'b1;
            mar_sel = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        case (op)
          OP_ADD:   d_add  = 1'b1;
          OP_LOAD:  d_load = 1'b1;
          OP_STORE: mem_wr = 1'b1;
          default:  ;
        endcase
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign state = state_q;

endmodule
